// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcode map and
// multiply/divide sequencer states.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_RSVD = 4'b1011;
  localparam logic [3:0] OP_MULT = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1110;
  localparam logic [3:0] OP_DIVU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  function automatic logic is_muldiv(
    input logic [3:0] op
  );
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider
// working on magnitudes, with a one-cycle sign fix-up.
module muldiv_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_a;
  logic             r_div;
  logic             neg_q;
  logic             neg_r;
  logic             r_dbz;

  logic             sgn;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign sgn   = ~op[0];
  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

  // r_hi is the accumulator / partial remainder,
  // r_lo the multiplier / dividend-quotient.
  assign add_s = {1'b0, r_hi}
               + (r_lo[0] ? {1'b0, r_b} : '0);
  assign shl   = {r_hi, r_lo[WIDTH-1]};
  assign trial = shl - {1'b0, r_b};

  assign prod     = {r_hi, r_lo};
  assign prod_fix = neg_q ? -prod : prod;

  assign busy = (state != IDLE);
  assign done = (state == FIX);
  assign dbz  = r_dbz;

  always_comb begin
    hi = prod_fix[2*WIDTH-1:WIDTH];
    lo = prod_fix[WIDTH-1:0];
    if (r_div) begin
      if (r_dbz) begin
        lo = '1;
        hi = r_a;
      end else begin
        lo = neg_q ? -r_lo : r_lo;
        hi = neg_r ? -r_hi : r_hi;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_a   <= '0;
      r_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      r_dbz <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            r_hi  <= '0;
            r_lo  <= mag_a;
            r_b   <= mag_b;
            r_a   <= a;
            r_div <= op[1];
            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn & a[WIDTH-1];
            r_dbz <= op[1] && (b == '0);
            state <= op[1] ? DIV : MUL;
          end
        end
        MUL: begin
          r_hi <= add_s[WIDTH:1];
          r_lo <= {add_s[0], r_lo[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          if (trial[WIDTH]) r_hi <= shl[WIDTH-1:0];
          else              r_hi <= trial[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], ~trial[WIDTH]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake and an
// iterative multiply/divide unit writing HI/LO.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             accept;
  logic             md_op;
  logic             md_busy;
  logic             md_done;
  logic             md_dbz;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;

  assign in_ready  = !md_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign md_op     = is_muldiv(op);
  assign zero_flag = (result == '0);

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1])
               && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1])
               && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                         $signed(a) < $signed(b)};
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = WIDTH'($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (accept && md_op),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo),
    .dbz   (md_dbz)
  );

  // md_done only occurs in FIX, where accept is blocked,
  // so the two result writers never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
        if (!md_op) begin
          out_valid <= 1'b1;
          result    <= alu_res;
          overflow  <= alu_ovf;
        end
      end
      if (md_done) begin
        out_valid   <= 1'b1;
        result      <= md_lo;
        hi          <= md_hi;
        lo          <= md_lo;
        div_by_zero <= md_dbz;
        overflow    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors push
// expectations, a monitor pops them on each consumed result.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        in_ready;
  logic        out_valid;
  logic        zero_flag;
  logic        overflow;
  logic        div_by_zero;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        ovf;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          errors = 0;
  int          checks = 0;

  seq_alu #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero_flag   (zero_flag),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none",
                 result);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("zero_flag", zero_flag, e.zf);
        check("overflow", overflow, e.ovf);
        check("div_by_zero", div_by_zero, e.dbz);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
      end
    end
  end

  task automatic send(input logic [3:0] o,
                      input logic [31:0] x,
                      input logic [31:0] y,
                      input exp_t e);
    int n;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic op1(input logic [3:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] r,
                     input logic ovf);
    exp_t e;
    e = '{r, (r == 32'h0), ovf, 1'b0, m_hi, m_lo};
    send(o, x, y, e);
  endtask

  task automatic opm(input logic [3:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] h,
                     input logic [31:0] l,
                     input logic dbz);
    exp_t e;
    m_hi = h;
    m_lo = l;
    e = '{l, (l == 32'h0), 1'b0, dbz, h, l};
    send(o, x, y, e);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++)
      @(negedge clk);
    check("drain_left", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_result"}, result, 32'h0);
    check({tag, "_zero_flag"}, zero_flag, 1'b1);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_dbz"}, div_by_zero, 1'b0);
    check({tag, "_hi"}, hi, 32'h0);
    check({tag, "_lo"}, lo, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    logic bad;
    exp_t dummy;

    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst_hold");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("rst_in_ready", in_ready, 1'b1);
    check_reset_vals("rst_rel");

    op1(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1);
    check("add_latency", out_valid, 1'b1);
    op1(4'b0110, 32'h5, 32'h5, 32'h0, 1'b0);
    op1(4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
    op1(4'b0101, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
    op1(4'b0011, 32'hFF00FF00, 32'h0F0F0F0F,
        32'hF00FF00F, 1'b0);
    op1(4'b0100, 32'hFFFF0000, 32'h0000FFFF, 32'h0, 1'b0);
    op1(4'b1010, 32'h80000000, 32'h4, 32'hF8000000, 1'b0);
    op1(4'b1001, 32'h80000000, 32'h24, 32'h08000000, 1'b0);
    op1(4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1);
    op1(4'b0010, 32'h80000000, 32'h80000000, 32'h0, 1'b1);
    op1(4'b1011, 32'h5, 32'h3, 32'h0, 1'b0);
    drain();

    opm(4'b1100, 32'hFFFFFFFD, 32'h7,
        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    n = 1;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) bad = 1'b1;
      @(posedge clk);
      n++;
    end
    check("mult_latency", 64'(n), 64'd34);
    check("mult_in_ready_low", bad, 1'b0);
    drain();

    opm(4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h00000001, 1'b0);
    opm(4'b1110, 32'hFFFFFFF9, 32'h2,
        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    opm(4'b1110, 32'h80000000, 32'hFFFFFFFF,
        32'h0, 32'h80000000, 1'b0);
    opm(4'b1111, 32'h9, 32'h0,
        32'h9, 32'hFFFFFFFF, 1'b1);
    drain();

    out_ready = 1'b0;
    op1(4'b1000, 32'h1, 32'd31, 32'h80000000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_result", result, 32'h80000000);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    op1(4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0);
    drain();

    dummy = '{32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    send(4'b1111, 32'd100, 32'd7, dummy);
    repeat (9) @(posedge clk);
    #1 check("mid_div_in_ready", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_vals("abort");
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("abort_in_ready", in_ready, 1'b1);

    op1(4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0);
    opm(4'b1101, 32'h6, 32'h7, 32'h0, 32'd42, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
